// File: rtl/core_pkg.sv
// Shared core types: load/store function codes and the memory arbiter state encoding.
package core_pkg;

  typedef enum logic [3:0] {
    LS_LB  = 4'd0,
    LS_LH  = 4'd1,
    LS_LW  = 4'd2,
    LS_LBU = 4'd3,
    LS_LHU = 4'd4,
    LS_SB  = 4'd5,
    LS_SH  = 4'd6,
    LS_SW  = 4'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_ACC = 2'd1,
    DATA_ACC  = 2'd2
  } mem_arb_state_e;

  localparam int unsigned STARVE_CNT_W = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating grant/stall counters for the memory arbiter (built only with MEM_ARB_PERF_CNT_EN).
`ifdef MEM_ARB_PERF_CNT_EN
module mem_arb_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             fetch_gnt_i,
  input  logic             lsu_gnt_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] fetch_gnt_cnt_o,
  output logic [CNT_W-1:0] lsu_gnt_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] lsu_cnt_q,   lsu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    lsu_cnt_d   = lsu_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_gnt_i && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 1'b1;
    if (lsu_gnt_i   && (lsu_cnt_q   != '1)) lsu_cnt_d   = lsu_cnt_q + 1'b1;
    if (stall_i     && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      lsu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      lsu_cnt_q   <= lsu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_gnt_cnt_o = fetch_cnt_q;
  assign lsu_gnt_cnt_o   = lsu_cnt_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port DRAM arbiter between instruction fetch and the LSU, one access in flight.
// Optional performance counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fetch_req_ip,
  input  logic [31:0]         fetch_addr_ip,
  output logic                fetch_gnt_op,
  output logic                fetch_rvalid_op,
  output logic [31:0]         fetch_rdata_op,
  input  logic                lsu_req_ip,
  input  logic [31:0]         lsu_addr_ip,
  input  load_store_func_code lsu_operator_ip,
  input  logic [31:0]         lsu_wdata_ip,
  output logic                lsu_gnt_op,
  output logic                lsu_rvalid_op,
  output logic [31:0]         lsu_rdata_op,
  output logic                mem_req_op,
  output logic [31:0]         mem_addr_op,
  output logic                mem_we_op,
  output logic [31:0]         mem_wdata_op,
  input  logic [31:0]         mem_rdata_ip
`ifdef MEM_ARB_PERF_CNT_EN
  , output logic [CNT_W-1:0]  fetch_gnt_cnt_op
  , output logic [CNT_W-1:0]  lsu_gnt_cnt_op
  , output logic [CNT_W-1:0]  stall_cnt_op
`endif
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  mem_arb_state_e            state_q, state_d;
  logic [STARVE_CNT_W-1:0]   starve_q, starve_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic                      fetch_rvalid_q, fetch_rvalid_d;
  logic                      lsu_rvalid_q, lsu_rvalid_d;
  logic [31:0]               fetch_rdata_q, fetch_rdata_d;
  logic [31:0]               lsu_rdata_q, lsu_rdata_d;
  logic                      fetch_gnt, lsu_gnt;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    fetch_rdata_d  = fetch_rdata_q;
    lsu_rdata_d    = lsu_rdata_q;
    fetch_rvalid_d = 1'b0;
    lsu_rvalid_d   = 1'b0;
    fetch_gnt      = 1'b0;
    lsu_gnt        = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset_n so grants stay low while reset is held.
        if (reset_n) begin
          if (fetch_req_ip && (!lsu_req_ip || (starve_q == LIMIT))) begin
            fetch_gnt = 1'b1;
            addr_d    = word_align(fetch_addr_ip);
            we_d      = 1'b0;
            state_d   = FETCH_ACC;
          end else if (lsu_req_ip) begin
            lsu_gnt = 1'b1;
            addr_d  = word_align(lsu_addr_ip);
            wdata_d = lsu_wdata_ip;
            we_d    = (lsu_operator_ip == LS_SW);
            state_d = DATA_ACC;
          end
        end
      end
      FETCH_ACC: begin
        fetch_rdata_d  = mem_rdata_ip;
        fetch_rvalid_d = 1'b1;
        state_d        = IDLE;
      end
      DATA_ACC: begin
        lsu_rdata_d  = we_q ? '0 : mem_rdata_ip;
        lsu_rvalid_d = 1'b1;
        we_d         = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!fetch_req_ip || fetch_gnt) begin
      starve_d = '0;
    end else if (lsu_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      lsu_rvalid_q   <= 1'b0;
      fetch_rdata_q  <= '0;
      lsu_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      lsu_rvalid_q   <= lsu_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
      lsu_rdata_q    <= lsu_rdata_d;
    end
  end

  assign fetch_gnt_op    = fetch_gnt;
  assign lsu_gnt_op      = lsu_gnt;
  assign fetch_rvalid_op = fetch_rvalid_q;
  assign lsu_rvalid_op   = lsu_rvalid_q;
  assign fetch_rdata_op  = fetch_rdata_q;
  assign lsu_rdata_op    = lsu_rdata_q;
  assign mem_req_op      = (state_q != IDLE);
  assign mem_addr_op     = addr_q;
  assign mem_we_op       = we_q && (state_q == DATA_ACC);
  assign mem_wdata_op    = wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clock           (clock),
    .reset_n         (reset_n),
    .fetch_gnt_i     (fetch_gnt),
    .lsu_gnt_i       (lsu_gnt),
    .stall_i         ((fetch_req_ip || lsu_req_ip) && !(fetch_gnt || lsu_gnt)),
    .fetch_gnt_cnt_o (fetch_gnt_cnt_op),
    .lsu_gnt_cnt_o   (lsu_gnt_cnt_op),
    .stall_cnt_o     (stall_cnt_op)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural DRAM.
module tb_mem_arbiter;
  import core_pkg::*;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                fetch_req;
  logic [31:0]         fetch_addr;
  logic                fetch_gnt, fetch_rvalid;
  logic [31:0]         fetch_rdata;
  logic                lsu_req;
  logic [31:0]         lsu_addr;
  load_store_func_code lsu_op;
  logic [31:0]         lsu_wdata;
  logic                lsu_gnt, lsu_rvalid;
  logic [31:0]         lsu_rdata;
  logic                mem_req, mem_we;
  logic [31:0]         mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0]         fetch_cnt, lsu_cnt, stall_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic        dram_load;
  logic [31:0] dram [0:63];

  always #5 clock = ~clock;

  assign mem_rdata = dram[mem_addr[7:2]];

  always @(posedge clock) begin
    if (dram_load) begin
      for (int i = 0; i < 64; i++)
        dram[i] <= (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
    end else if (mem_req && mem_we) begin
      dram[mem_addr[7:2]] <= mem_wdata;
    end
  end

  mem_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .fetch_req_ip    (fetch_req),
    .fetch_addr_ip   (fetch_addr),
    .fetch_gnt_op    (fetch_gnt),
    .fetch_rvalid_op (fetch_rvalid),
    .fetch_rdata_op  (fetch_rdata),
    .lsu_req_ip      (lsu_req),
    .lsu_addr_ip     (lsu_addr),
    .lsu_operator_ip (lsu_op),
    .lsu_wdata_ip    (lsu_wdata),
    .lsu_gnt_op      (lsu_gnt),
    .lsu_rvalid_op   (lsu_rvalid),
    .lsu_rdata_op    (lsu_rdata),
    .mem_req_op      (mem_req),
    .mem_addr_op     (mem_addr),
    .mem_we_op       (mem_we),
    .mem_wdata_op    (mem_wdata),
    .mem_rdata_ip    (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .fetch_gnt_cnt_op (fetch_cnt)
    , .lsu_gnt_cnt_op   (lsu_cnt)
    , .stall_cnt_op     (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned grants;
    reset_n    = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    lsu_req    = 1'b0;
    lsu_addr   = '0;
    lsu_op     = LS_LW;
    lsu_wdata  = '0;
    dram_load  = 1'b1;

    // Reset state, including grants held low with a request present.
    tick();
    tick();
    fetch_req = 1'b1;
    #1;
    check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_rvalids",   {30'd0, fetch_rvalid, lsu_rvalid}, 32'd0);
    check("rst_rdata",     fetch_rdata | lsu_rdata, 32'd0);
    fetch_req = 1'b0;
    tick();
    reset_n   = 1'b1;
    dram_load = 1'b0;
    tick();

    // Fetch only: gnt N, access N+1, rvalid N+2.
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    #1;
    check("t1_gnt",     32'(fetch_gnt), 32'd1);
    check("t1_lsu_gnt", 32'(lsu_gnt),   32'd0);
    tick();
    fetch_req = 1'b0;
    #1;
    check("t1_mem_req",  32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr,     32'h10);
    check("t1_mem_we",   32'(mem_we),  32'd0);
    tick();
    #1;
    check("t1_rvalid",     32'(fetch_rvalid), 32'd1);
    check("t1_rdata",      fetch_rdata,       32'hDEAD_BEEF);
    check("t1_lsu_rvalid", 32'(lsu_rvalid),   32'd0);
    tick();
    #1;
    check("t1_rvalid_off", 32'(fetch_rvalid), 32'd0);
    check("t1_rdata_hold", fetch_rdata,       32'hDEAD_BEEF);
    check("t1_idle",       32'(mem_req),      32'd0);

    // SW then back-to-back LW at the same address.
    lsu_req   = 1'b1;
    lsu_op    = LS_SW;
    lsu_addr  = 32'h8;
    lsu_wdata = 32'h1234_5678;
    #1;
    check("t2_sw_gnt", 32'(lsu_gnt), 32'd1);
    check("t2_we_pre", 32'(mem_we),  32'd0);
    tick();
    lsu_req = 1'b0;
    #1;
    check("t2_we_acc",  32'(mem_we),  32'd1);
    check("t2_addr",    mem_addr,     32'h8);
    check("t2_wdata",   mem_wdata,    32'h1234_5678);
    tick();
    lsu_req = 1'b1;
    lsu_op  = LS_LW;
    #1;
    check("t2_sw_rvalid", 32'(lsu_rvalid), 32'd1);
    check("t2_sw_rdata",  lsu_rdata,       32'd0);
    check("t2_we_post",   32'(mem_we),     32'd0);
    check("t2_lw_gnt",    32'(lsu_gnt),    32'd1);
    tick();
    lsu_req = 1'b0;
    #1;
    check("t2_lw_we",     32'(mem_we),     32'd0);
    check("t2_lw_req",    32'(mem_req),    32'd1);
    tick();
    #1;
    check("t2_lw_rvalid", 32'(lsu_rvalid),   32'd1);
    check("t2_lw_rdata",  lsu_rdata,         32'h1234_5678);
    check("t2_no_fetch",  32'(fetch_rvalid), 32'd0);

    // Misaligned LW: low address bits dropped.
    tick();
    lsu_req  = 1'b1;
    lsu_op   = LS_LW;
    lsu_addr = 32'h0B;
    #1;
    check("t5_gnt", 32'(lsu_gnt), 32'd1);
    tick();
    lsu_req = 1'b0;
    #1;
    check("t5_addr", mem_addr, 32'h08);
    tick();
    #1;
    check("t5_rdata", lsu_rdata, 32'h1234_5678);

    // Request raised and dropped while busy is never served.
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    #1;
    check("drop_fgnt", 32'(fetch_gnt), 32'd1);
    tick();
    fetch_req = 1'b0;
    lsu_req   = 1'b1;
    lsu_op    = LS_SW;
    lsu_addr  = 32'h20;
    lsu_wdata = 32'h1;
    #1;
    check("drop_busy_gnt", 32'(lsu_gnt), 32'd0);
    tick();
    lsu_req = 1'b0;
    #1;
    check("drop_idle_gnt", 32'(lsu_gnt), 32'd0);
    tick();
    #1;
    check("drop_no_access", 32'(mem_req), 32'd0);

    // Reset during a store access.
    lsu_req   = 1'b1;
    lsu_op    = LS_SW;
    lsu_addr  = 32'h20;
    lsu_wdata = 32'hCAFE_F00D;
    #1;
    check("t4_gnt", 32'(lsu_gnt), 32'd1);
    tick();
    lsu_req = 1'b0;
    #1;
    check("t4_in_acc", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_req",   32'(mem_req),  32'd0);
    check("t4_we",    32'(mem_we),   32'd0);
    check("t4_addr",  mem_addr,      32'd0);
    check("t4_wdata", mem_wdata,     32'd0);
    check("t4_rdata", lsu_rdata | fetch_rdata, 32'd0);
    tick();
    check("t4_rv_rst", 32'(lsu_rvalid), 32'd0);
    reset_n = 1'b1;
    tick();
    check("t4_rv_post1", 32'(lsu_rvalid), 32'd0);
    tick();
    check("t4_rv_post2", 32'(lsu_rvalid), 32'd0);
    lsu_req = 1'b1;
    lsu_op  = LS_LW;
    #1;
    check("t4_lw_gnt", 32'(lsu_gnt), 32'd1);
    tick();
    lsu_req = 1'b0;
    tick();
    #1;
    check("t4_lw_rvalid", 32'(lsu_rvalid), 32'd1);
    check("t4_lw_rdata",  lsu_rdata,       32'hA500_0008);

    // Both requesting: LSU wins four times, then fetch.
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    lsu_req    = 1'b1;
    lsu_op     = LS_LW;
    lsu_addr   = 32'h4;
    grants     = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (fetch_gnt || lsu_gnt) begin
        check($sformatf("t3_order%0d", grants), {30'd0, fetch_gnt, lsu_gnt},
              ((grants % 5) == 4) ? 32'd2 : 32'd1);
        grants++;
      end
      if (grants == 20) break;
      tick();
    end
    check("t3_grant_count", grants, 32'd20);
    tick();
    fetch_req = 1'b0;
    lsu_req   = 1'b0;
    tick();

`ifdef MEM_ARB_PERF_CNT_EN
    // Ten back-to-back fetches from a fresh reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    repeat (20) tick();
    fetch_req = 1'b0;
    tick();
    #1;
    check("t6_fetch_cnt", 32'(fetch_cnt), 32'd10);
    check("t6_lsu_cnt",   32'(lsu_cnt),   32'd0);
    check("t6_stall_cnt", 32'(stall_cnt), 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
